// File: rtl/count_snapshot_fifo.sv
`default_nettype none
// ============================================================================
// Module   : count_snapshot_fifo
// Brief    : Captures counter values on a strobe or on counter wrap into a
//            small FIFO and presents them over a valid/ready interface.
//            Define COUNT_SNAPSHOT_OVERWRITE_EN to let a capture into a full
//            FIFO replace the oldest entry instead of being dropped.
// Revision : 1.0 - initial release
// ============================================================================
module count_snapshot_fifo #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              snap,
    input  logic              auto_wrap,
    input  logic              clear_ovf,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              wrap_pulse
);

    localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_lvl_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_lvl_full = (ADDR_W+1)'(DEPTH);
    localparam logic [WIDTH-1:0]  c_all_ones = '1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [WIDTH-1:0]  r_prev_count;
    logic              r_wrap_pulse;
    logic              r_overflow;

    logic w_wrap;
    logic w_cap;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_wr_en;
    logic w_rd_adv;

    assign full       = (r_level == c_lvl_full);
    assign empty      = (r_level == '0);
    assign out_valid  = ~empty;
    assign out_data   = empty ? '0 : r_mem[r_rd_ptr];
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign wrap_pulse = r_wrap_pulse;

    assign w_wrap = (r_prev_count == c_all_ones) && (count_in == '0);
    assign w_cap  = snap | (auto_wrap & w_wrap);
    assign w_pop  = out_valid & out_ready;
    assign w_push = w_cap & (~full | w_pop);
    assign w_drop = w_cap & full & ~w_pop;

`ifdef COUNT_SNAPSHOT_OVERWRITE_EN
    // A lost capture lands in the head slot; advancing both pointers makes the
    // next-oldest entry the new head while level stays at DEPTH.
    assign w_wr_en  = w_push | w_drop;
    assign w_rd_adv = w_pop | w_drop;
`else
    assign w_wr_en  = w_push;
    assign w_rd_adv = w_pop;
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= count_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_prev_count <= '0;
            r_wrap_pulse <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_prev_count <= count_in;
            r_wrap_pulse <= w_wrap;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_lvl_one;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_lvl_one;
            end
            // A new loss takes priority over a coincident clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_snapshot_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_snapshot_fifo
// Brief    : Scoreboard bench for count_snapshot_fifo; expected drain values
//            are queued at stimulus time and checked by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_snapshot_fifo;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  count_in;
    logic              snap;
    logic              auto_wrap;
    logic              clear_ovf;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              wrap_pulse;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q [$];

    count_snapshot_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .snap      (snap),
        .auto_wrap (auto_wrap),
        .clear_ovf (clear_ovf),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .wrap_pulse(wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each negedge with a live handshake is exactly one pop on the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL drain: got unexpected %0h, expected nothing", out_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL drain: got %0h, expected %0h", out_data, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; count_in = '0; snap = 1'b0; auto_wrap = 1'b0;
        clear_ovf = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst full", int'(full), 0);
        chk("rst level", int'(level), 0);
        chk("rst overflow", int'(overflow), 0);
        chk("rst wrap_pulse", int'(wrap_pulse), 0);
        chk("rst out_data", int'(out_data), 0);

        // Two snaps, then drain
        count_in = 4'h3; snap = 1'b1; exp_q.push_back(4'h3);
        tick();
        chk("snap1 out_valid", int'(out_valid), 1);
        chk("snap1 out_data", int'(out_data), 3);
        chk("snap1 level", int'(level), 1);
        count_in = 4'h7; exp_q.push_back(4'h7);
        tick();
        snap = 1'b0;
        chk("snap2 level", int'(level), 2);
        chk("snap2 hold data", int'(out_data), 3);
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        chk("drain empty", int'(empty), 1);

        // Auto-wrap capture
        auto_wrap = 1'b1;
        count_in = 4'hE; tick();
        count_in = 4'hF; tick();
        count_in = 4'h0; exp_q.push_back(4'h0);
        chk("pre-wrap pulse", int'(wrap_pulse), 0);
        tick();
        chk("wrap pulse", int'(wrap_pulse), 1);
        chk("wrap level", int'(level), 1);
        count_in = 4'h1; tick();
        chk("wrap pulse end", int'(wrap_pulse), 0);
        // Snap coincident with wrap gives a single capture
        count_in = 4'hF; tick();
        count_in = 4'h0; snap = 1'b1; exp_q.push_back(4'h0);
        tick();
        snap = 1'b0; count_in = 4'h1;
        chk("snap+wrap level", int'(level), 2);
        auto_wrap = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        chk("wrap drain empty", int'(empty), 1);

        // Fill 0..7, then capture into a full FIFO
        snap = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            count_in = WIDTH'(i); exp_q.push_back(WIDTH'(i));
            tick();
        end
        count_in = 4'h9;
`ifdef COUNT_SNAPSHOT_OVERWRITE_EN
        void'(exp_q.pop_front()); exp_q.push_back(4'h9);
`endif
        tick();
        snap = 1'b0;
        chk("full flag", int'(full), 1);
        chk("full level", int'(level), 8);
        chk("ovf set", int'(overflow), 1);
`ifdef COUNT_SNAPSHOT_OVERWRITE_EN
        chk("overwrite head", int'(out_data), 1);
`else
        chk("drop head", int'(out_data), 0);
`endif
        // Clear coincident with a new loss: set wins
        clear_ovf = 1'b1; snap = 1'b1; count_in = 4'hC;
`ifdef COUNT_SNAPSHOT_OVERWRITE_EN
        void'(exp_q.pop_front()); exp_q.push_back(4'hC);
`endif
        tick();
        snap = 1'b0;
        chk("ovf set wins", int'(overflow), 1);
        tick();
        clear_ovf = 1'b0;
        chk("ovf cleared", int'(overflow), 0);
        chk("level after clr", int'(level), 8);

        // Full with simultaneous push and pop
        out_ready = 1'b1; snap = 1'b1; count_in = 4'hA; exp_q.push_back(4'hA);
        tick();
        out_ready = 1'b0; snap = 1'b0;
        chk("push+pop level", int'(level), 8);
        chk("push+pop ovf", int'(overflow), 0);
        chk("push+pop full", int'(full), 1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        out_ready = 1'b0;
        chk("full drain empty", int'(empty), 1);
        chk("scoreboard empty", exp_q.size(), 0);

        // Ready while empty does nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ready-empty level", int'(level), 0);

        // Asynchronous reset mid-cycle while holding data and overflow
        snap = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            count_in = WIDTH'(i + 2);
            tick();
        end
        snap = 1'b0;
        chk("pre-rst ovf", int'(overflow), 1);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async out_valid", int'(out_valid), 0);
        chk("async empty", int'(empty), 1);
        chk("async level", int'(level), 0);
        chk("async overflow", int'(overflow), 0);
        chk("async wrap_pulse", int'(wrap_pulse), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post-rst level", int'(level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_snapshot_fifo.md
Name: count_snapshot_fifo

Overview:
- Downstream stage of the 4-bit up counter: captures counter values on a strobe or on counter wrap, buffers them in a small FIFO, and presents them to a consumer over a valid/ready interface.
- Decouples the free-running counter from a slower consumer, such as a display or logger stage.

Parameters:
- WIDTH, 4, bit width of captured count values.
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.
- ADDR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- count_in  input  WIDTH  current counter value from the upstream counter.
- snap  input  1  capture request; samples count_in this cycle.
- auto_wrap  input  1  when 1, a counter wrap (all-ones to zero) also generates a capture.
- clear_ovf  input  1  synchronous clear of the overflow flag.
- out_data  output  WIDTH  value at the FIFO head.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts the head.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- level  output  ADDR_W+1  entries stored, 0..DEPTH.
- overflow  output  1  sticky; a capture was lost.
- wrap_pulse  output  1  one-cycle pulse on detected counter wrap.

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: out_data=0, out_valid=0, full=0, empty=1, level=0, overflow=0, wrap_pulse=0.
  - Pointers and prev_count are cleared to 0.
  - Reset mid-operation discards all stored entries. There is no partial pop; the consumer sees out_valid fall immediately.
- Wrap detect:
  - prev_count is registered each cycle.
  - Wrap is defined as prev_count == all-ones and count_in == 0.
  - wrap_pulse is registered and asserts the cycle after the wrap is observed.
  - The first cycle after reset never flags a wrap, because prev_count=0.
- Capture request:
  - cap = snap | (auto_wrap & wrap_detect_comb).
  - snap and wrap in the same cycle produce a single capture.
  - The captured value is count_in at that edge.
- Push and pop:
  - push = cap & (~full | pop).
  - pop = out_valid & out_ready.
- Simultaneous push and pop:
  - level is unchanged and both pointers advance.
  - When full, the push is accepted because a slot is freed the same cycle.
- Empty FIFO:
  - No bypass. A capture while empty makes out_valid=1 on the next cycle.
  - Capture-to-valid latency is 1 cycle.
- Handshake:
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
  - out_ready while empty has no effect.
- Pointer arithmetic:
  - Pointers are ADDR_W bits and wrap modulo DEPTH.
  - level is tracked as ADDR_W+1 bits: +1 on push-only, -1 on pop-only.
- Overflow:
  - Set when cap=1, full=1 and pop=0; the capture is dropped.
  - Cleared only by clear_ovf or reset.
  - If clear_ovf and a new overflow coincide, set wins.
- full and empty are derived from registered level, with no combinational path from inputs.

Optional Feature:
- Macro: COUNT_SNAPSHOT_OVERWRITE_EN.
- Defined: a capture while full and not popping overwrites the oldest entry.
  - Head and tail both advance; level stays DEPTH.
  - overflow still sets.
  - out_data updates to the new oldest entry the next cycle.
- Undefined: the new capture is dropped and the stored contents are untouched.

Test Plan:
- Reset with rst=1 asynchronously mid-cycle -> immediately out_valid=0, empty=1, level=0, overflow=0, wrap_pulse=0.
- snap with count_in=4'h3, then 4'h7; out_ready=0 -> one cycle later out_valid=1, out_data=3; level=2. Then out_ready=1 for 2 cycles -> outputs 3 then 7; then empty=1.
- auto_wrap=1, counter runs 4'hE,4'hF,4'h0 -> wrap_pulse high one cycle after the 0 appears; captured value 0; with snap=1 in the same cycle, level increments by only 1.
- Fill 8 entries (values 0..7), out_ready=0, snap with 4'h9:
  - Without macro -> overflow=1, level=8, drain yields 0..7.
  - With macro -> drain yields 1..7,9.
- Full FIFO, snap=1 and out_ready=1 same cycle with count_in=4'hA -> level stays 8, overflow=0, 4'hA is the last entry drained.
- overflow=1, then clear_ovf=1 with no capture -> overflow=0 next cycle. clear_ovf coincident with a new dropped capture -> overflow stays 1.
